// File: rtl/com_pkg.sv
`default_nettype none
// ============================================================================
// Module      : com_pkg
// Description : Shared types and default sizing for the fault status block.
// Revision    : 1.0 - initial release
// ============================================================================
package com_pkg;

    typedef enum logic {
        INTB_LEVEL = 1'b0,
        INTB_PULSE = 1'b1
    } intb_mode_e;

    localparam int FLT_NUM_DFT      = 8;
    localparam int FLT_DGL_W_DFT    = 4;
    localparam int INTB_PULSE_W_DFT = 8;

endpackage
`default_nettype wire

// File: rtl/flt_dgl.sv
`default_nettype none
// ============================================================================
// Module      : flt_dgl
// Description : Single-channel fault deglitch; FLT_DGL_EN selects the counter
//               qualifier, otherwise the raw level is simply registered.
// Revision    : 1.0 - initial release
// ============================================================================
module flt_dgl
    import com_pkg::*;
#(
    parameter int DGL_W = FLT_DGL_W_DFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flt_raw,
    input  logic [DGL_W-1:0] dgl_thr,
    output logic             flt_vld
);

    logic r_vld;

`ifdef FLT_DGL_EN
    localparam logic [DGL_W-1:0] c_cnt_one = DGL_W'(1);

    logic [DGL_W-1:0] r_cnt;

    // Comparing with >= lets a lowered threshold qualify on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (!flt_raw) begin
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (r_cnt >= dgl_thr) begin
            r_vld <= 1'b1;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end
`else
    logic w_unused_thr;
    assign w_unused_thr = ^dgl_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= flt_raw;
        end
    end
`endif

    assign flt_vld = r_vld;

endmodule
`default_nettype wire

// File: rtl/flt_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flt_status_ctrl
// Description : Per-channel fault deglitch (FLT_DGL_EN), sticky W1C status,
//               interrupt mask and level/pulse active-low interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module flt_status_ctrl
    import com_pkg::*;
#(
    parameter int NUM_FLT      = FLT_NUM_DFT,
    parameter int DGL_W        = FLT_DGL_W_DFT,
    parameter int INTB_PULSE_W = INTB_PULSE_W_DFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_FLT-1:0] flt_raw,
    input  logic               reg_wr_en,
    input  logic               reg_wr_sel,
    input  logic [NUM_FLT-1:0] reg_wr_data,
    input  logic [DGL_W-1:0]   dgl_thr,
    input  logic               intb_mode,
    output logic [NUM_FLT-1:0] flt_vld,
    output logic [NUM_FLT-1:0] status,
    output logic [NUM_FLT-1:0] mask,
    output logic               intb
);

    localparam int                c_pcnt_w     = $clog2(INTB_PULSE_W + 1);
    localparam logic [c_pcnt_w-1:0] c_pulse_load = c_pcnt_w'(INTB_PULSE_W);
    localparam logic [c_pcnt_w-1:0] c_pcnt_one   = c_pcnt_w'(1);

    logic [NUM_FLT-1:0]  r_status;
    logic [NUM_FLT-1:0]  r_mask;
    logic [NUM_FLT-1:0]  r_pend_q;
    logic [c_pcnt_w-1:0] r_pcnt;
    logic                r_intb;

    logic [NUM_FLT-1:0]  w_clr;
    logic [NUM_FLT-1:0]  w_status_nxt;
    logic [NUM_FLT-1:0]  w_pend;
    logic                w_irq;
    logic                w_event;
    logic                w_pulse_mode;
    logic [c_pcnt_w-1:0] w_pcnt_nxt;
    logic                w_intb_nxt;

    for (genvar gi = 0; gi < NUM_FLT; gi++) begin : g_dgl
        flt_dgl #(
            .DGL_W (DGL_W)
        ) u_dgl (
            .clk     (clk),
            .rst_n   (rst_n),
            .flt_raw (flt_raw[gi]),
            .dgl_thr (dgl_thr),
            .flt_vld (flt_vld[gi])
        );
    end

    // Set is OR-ed after the clear so an active fault wins over a W1C.
    assign w_clr        = (reg_wr_en && !reg_wr_sel) ? reg_wr_data : '0;
    assign w_status_nxt = (r_status & ~w_clr) | flt_vld;

    assign w_pend       = r_status & ~r_mask;
    assign w_irq        = |w_pend;
    assign w_event      = |(w_pend & ~r_pend_q);
    assign w_pulse_mode = (intb_mode_e'(intb_mode) == INTB_PULSE);

    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (!w_pulse_mode) begin
            w_pcnt_nxt = '0;
        end else if (w_event) begin
            w_pcnt_nxt = c_pulse_load;
        end else if (r_pcnt != '0) begin
            w_pcnt_nxt = r_pcnt - c_pcnt_one;
        end
    end

    assign w_intb_nxt = w_pulse_mode ? (w_pcnt_nxt == '0) : ~w_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= '0;
            r_mask   <= '1;
            r_pend_q <= '0;
            r_pcnt   <= '0;
            r_intb   <= 1'b1;
        end else begin
            r_status <= w_status_nxt;
            if (reg_wr_en && reg_wr_sel) begin
                r_mask <= reg_wr_data;
            end
            r_pend_q <= w_pend;
            r_pcnt   <= w_pcnt_nxt;
            r_intb   <= w_intb_nxt;
        end
    end

    assign status = r_status;
    assign mask   = r_mask;
    assign intb   = r_intb;

endmodule
`default_nettype wire

// File: tb/tb_flt_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_flt_status_ctrl
// Description : Self-checking bench for flt_status_ctrl (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flt_status_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] flt_raw;
    logic       reg_wr_en;
    logic       reg_wr_sel;
    logic [7:0] reg_wr_data;
    logic [3:0] dgl_thr;
    logic       intb_mode;
    logic [7:0] flt_vld;
    logic [7:0] status;
    logic [7:0] mask;
    logic       intb;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] raw;
        logic       wr_en;
        logic       wr_sel;
        logic [7:0] wr_data;
        logic [7:0] e_vld;
        logic [7:0] e_status;
        logic [7:0] e_mask;
        logic       e_intb;
    } vec_t;

    typedef struct {
        logic [7:0] vld;
        logic [7:0] status;
        logic [7:0] mask;
        logic       intb;
    } exp_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];
    exp_t sb[$];

    flt_status_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flt_raw     (flt_raw),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_sel  (reg_wr_sel),
        .reg_wr_data (reg_wr_data),
        .dgl_thr     (dgl_thr),
        .intb_mode   (intb_mode),
        .flt_vld     (flt_vld),
        .status      (status),
        .mask        (mask),
        .intb        (intb)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] raw, input logic we, input logic ws,
                                input logic [7:0] wd, input logic [7:0] ev,
                                input logic [7:0] es, input logic [7:0] em, input logic ei);
        vec_t v;
        v.raw = raw; v.wr_en = we; v.wr_sel = ws; v.wr_data = wd;
        v.e_vld = ev; v.e_status = es; v.e_mask = em; v.e_intb = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [7:0] d);
        reg_wr_en   = 1'b1;
        reg_wr_sel  = sel;
        reg_wr_data = d;
        @(negedge clk);
        reg_wr_en   = 1'b0;
        reg_wr_data = 8'h00;
    endtask

    task automatic count_lows(input int n, output int lows, output int first, output int last);
        lows = 0; first = -1; last = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (intb === 1'b0) begin
                lows++;
                if (first < 0) first = k;
                last = k;
            end
        end
    endtask

    initial begin
        int lows, first, last;
        exp_t e;

        rst_n = 1'b0; flt_raw = 8'h00; reg_wr_en = 1'b0; reg_wr_sel = 1'b0;
        reg_wr_data = 8'h00; dgl_thr = 4'd0; intb_mode = 1'b0;

        // Level-mode register behaviour; threshold 0 gives 1-cycle qualification in both builds.
        vecs[0]  = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
        vecs[1]  = mk(8'h10, 0, 0, 8'h00, 8'h10, 8'h00, 8'hFF, 1);
        vecs[2]  = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h10, 8'hFF, 1);
        vecs[3]  = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h10, 8'hFF, 1);
        vecs[4]  = mk(8'h00, 1, 1, 8'hEF, 8'h00, 8'h10, 8'hEF, 1);
        vecs[5]  = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h10, 8'hEF, 0);
        vecs[6]  = mk(8'h00, 1, 1, 8'hFF, 8'h00, 8'h10, 8'hFF, 0);
        vecs[7]  = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h10, 8'hFF, 1);
        vecs[8]  = mk(8'h04, 0, 0, 8'h00, 8'h04, 8'h10, 8'hFF, 1);
        vecs[9]  = mk(8'h04, 0, 0, 8'h00, 8'h04, 8'h14, 8'hFF, 1);
        vecs[10] = mk(8'h04, 1, 0, 8'h14, 8'h04, 8'h04, 8'hFF, 1);
        vecs[11] = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h04, 8'hFF, 1);
        vecs[12] = mk(8'h00, 1, 0, 8'h04, 8'h00, 8'h00, 8'hFF, 1);
        vecs[13] = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
        vecs[14] = mk(8'h81, 0, 0, 8'h00, 8'h81, 8'h00, 8'hFF, 1);
        vecs[15] = mk(8'h00, 1, 1, 8'h7F, 8'h00, 8'h81, 8'h7F, 1);
        vecs[16] = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h81, 8'h7F, 0);
        vecs[17] = mk(8'h00, 1, 0, 8'h80, 8'h00, 8'h01, 8'h7F, 0);
        vecs[18] = mk(8'h00, 0, 0, 8'h00, 8'h00, 8'h01, 8'h7F, 1);
        vecs[19] = mk(8'h00, 1, 0, 8'h01, 8'h00, 8'h00, 8'h7F, 1);
        vecs[20] = mk(8'h00, 1, 1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1);

        @(negedge clk);
        chk("rst_vld", flt_vld, 8'h00);
        chk("rst_status", status, 8'h00);
        chk("rst_mask", mask, 8'hFF);
        chk("rst_intb", intb, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            flt_raw = vecs[i].raw; reg_wr_en = vecs[i].wr_en;
            reg_wr_sel = vecs[i].wr_sel; reg_wr_data = vecs[i].wr_data;
            sb.push_back('{vecs[i].e_vld, vecs[i].e_status, vecs[i].e_mask, vecs[i].e_intb});
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("vec%0d_vld", i), flt_vld, e.vld);
            chk($sformatf("vec%0d_status", i), status, e.status);
            chk($sformatf("vec%0d_mask", i), mask, e.mask);
            chk($sformatf("vec%0d_intb", i), intb, e.intb);
        end
        reg_wr_en = 1'b0; reg_wr_data = 8'h00; flt_raw = 8'h00;

        // Pulse retrigger: ch0 then ch5 four cycles later stretches to 12 low cycles.
        intb_mode = 1'b1;
        wr(1'b1, 8'h00);
        flt_raw = 8'h01;
        lows = 0; first = -1; last = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (intb === 1'b0) begin
                lows++;
                if (first < 0) first = k;
                last = k;
            end
            if (k == 4) flt_raw = 8'h21;
        end
        chk("retrig_lows", lows, 12);
        chk("retrig_first", first, 3);
        chk("retrig_span", last - first + 1, 12);
        chk("retrig_end_intb", intb, 1'b1);
        chk("retrig_status", status, 8'h21);

        // Masking never pulses; unmasking a set bit does; clearing does not.
        flt_raw = 8'h00;
        wr(1'b1, 8'hFF);
        count_lows(5, lows, first, last);
        chk("mask_no_pulse", lows, 0);
        wr(1'b1, 8'hDF);
        count_lows(12, lows, first, last);
        chk("unmask_pulse_lows", lows, 8);
        wr(1'b0, 8'h20);
        chk("clr_status", status, 8'h01);
        count_lows(6, lows, first, last);
        chk("clr_no_pulse", lows, 0);

        // Mode switch mid-pulse clears the counter; returning to pulse mode with irq set stays quiet.
        wr(1'b1, 8'h00);
        @(negedge clk);
        chk("mode_pulse_start", intb, 1'b0);
        @(negedge clk);
        intb_mode = 1'b0;
        @(negedge clk);
        chk("mode_level_intb", intb, 1'b0);
        intb_mode = 1'b1;
        count_lows(10, lows, first, last);
        chk("mode_switch_no_pulse", lows, 0);

        // Asynchronous reset in the middle of a pulse.
        wr(1'b1, 8'hFF);
        wr(1'b1, 8'h00);
        @(negedge clk);
        chk("pre_rst_intb", intb, 1'b0);
        chk("pre_rst_status", status, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_intb", intb, 1'b1);
        chk("async_rst_status", status, 8'h00);
        chk("async_rst_mask", mask, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        intb_mode = 1'b0;

`ifdef FLT_DGL_EN
        dgl_thr = 4'd3;
        flt_raw = 8'h04;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("dgl_short_vld%0d", k), flt_vld, 8'h00);
        end
        flt_raw = 8'h00;
        @(negedge clk);
        chk("dgl_short_vld_low", flt_vld, 8'h00);
        chk("dgl_short_status", status, 8'h00);
        flt_raw = 8'h04;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("dgl_long_vld%0d", k), flt_vld, (k >= 4) ? 8'h04 : 8'h00);
        end
        flt_raw = 8'h00;
        @(negedge clk);
        chk("dgl_long_vld_fall", flt_vld, 8'h00);
        chk("dgl_long_status", status, 8'h04);
        dgl_thr = 4'd7;
        flt_raw = 8'h01;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        chk("thr_lower_pre", flt_vld, 8'h00);
        dgl_thr = 4'd1;
        @(negedge clk);
        chk("thr_lower_vld", flt_vld, 8'h01);
        flt_raw = 8'h00;
`else
        dgl_thr = 4'd15;
        flt_raw = 8'h01;
        @(negedge clk);
        chk("glitch_vld_hi", flt_vld, 8'h01);
        flt_raw = 8'h00;
        @(negedge clk);
        chk("glitch_vld_lo", flt_vld, 8'h00);
        chk("glitch_status", status, 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
